// File: rtl/obi_demux_1_to_2.sv
// obi_demux_1_to_2
// One OBI master fanned out to two OBI slaves by address decode. Slave 1
// owns the region (addr & S1_MASK) == S1_BASE; every other address goes to
// slave 0. Up to MAX_OUTSTANDING reads may be in flight, and all of them
// target the same slave, so read responses come back to the master in order.
//
// Optional feature, macro OBI_DEMUX_ERR_RESP_EN: addresses outside the slave 1
// region whose masked bits are non-zero form an "unmapped" region. Requests
// there never reach a slave. An internal responder grants them in the same
// cycle. Reads return 32'hBADC_AB1E one cycle after the grant. Writes are
// dropped.
//
// Handshake: the address phase completes in a cycle where m_req_i and m_gnt_o
// are both high, and m_gnt_o is a zero-cycle passthrough of the selected
// slave's gnt. The response phase is one cycle wide, marked by m_rvalid_o,
// and exists only for reads. Once sN_req_o rises it stays high until the
// grant, because nothing that blocks a request can change while it waits.
module obi_demux_1_to_2 #(
  parameter logic [31:0] S1_BASE         = 32'h1000_0000,
  parameter logic [31:0] S1_MASK         = 32'hF000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // master-facing port (this block acts as the slave)
  input  logic          m_req_i,
  output logic          m_gnt_o,
  input  logic [31:0]   m_addr_i,
  input  logic          m_we_i,
  input  logic [3:0]    m_be_i,
  input  logic [31:0]   m_wdata_i,
  output logic          m_rvalid_o,
  output logic [31:0]   m_rdata_o,
  // slave 0 port
  output logic          s0_req_o,
  input  logic          s0_gnt_i,
  output logic [31:0]   s0_addr_o,
  output logic          s0_we_o,
  output logic [3:0]    s0_be_o,
  output logic [31:0]   s0_wdata_o,
  input  logic          s0_rvalid_i,
  input  logic [31:0]   s0_rdata_i,
  // slave 1 port
  output logic          s1_req_o,
  input  logic          s1_gnt_i,
  output logic [31:0]   s1_addr_o,
  output logic          s1_we_o,
  output logic [3:0]    s1_be_o,
  output logic [31:0]   s1_wdata_o,
  input  logic          s1_rvalid_i,
  input  logic [31:0]   s1_rdata_i,
  // debug view of the tracking state
  output logic [CW-1:0] dbg_cnt_o,
  output logic [1:0]    dbg_route_o
);

`ifdef OBI_DEMUX_ERR_RESP_EN
  localparam int unsigned RW = 2;
`else
  localparam int unsigned RW = 1;
`endif

  localparam logic [RW-1:0] R_S0    = RW'(0);
  localparam logic [RW-1:0] R_S1    = RW'(1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
`ifdef OBI_DEMUX_ERR_RESP_EN
  localparam logic [RW-1:0] R_ERR     = RW'(2);
  localparam logic [31:0]   ERR_RDATA = 32'hBADC_AB1E;
`endif

  // tracking state: number of reads in flight and the target they all share
  logic [CW-1:0] cnt;
  logic [RW-1:0] route;

  // combinational decode and handshake terms
  logic          hit_s1;
  logic [RW-1:0] sel;
  logic          tgt_gnt;
  logic [CW-1:0] lim;
  logic          same_route;
  logic          allowed_rd;
  logic          allowed_wr;
  logic          allowed;
  logic          rd_accept;
  logic          route_rvalid;
  logic [31:0]   route_rdata;
  logic          rvalid_in;

`ifdef OBI_DEMUX_ERR_RESP_EN
  logic unmapped;
  logic err_pending;
`endif

  assign hit_s1 = ((m_addr_i & S1_MASK) == S1_BASE);
`ifdef OBI_DEMUX_ERR_RESP_EN
  assign unmapped = !hit_s1 && ((m_addr_i & S1_MASK) != 32'h0);
`endif

  // address decode: pick the target of the current request
  always_comb begin
    sel = R_S0;
    if (hit_s1) begin
      sel = R_S1;
    end
`ifdef OBI_DEMUX_ERR_RESP_EN
    else if (unmapped) begin
      sel = R_ERR;
    end
`endif
  end

  // grant offered by whichever target the request decodes to
  always_comb begin
    tgt_gnt = s0_gnt_i;
    if (sel == R_S1) begin
      tgt_gnt = s1_gnt_i;
    end
`ifdef OBI_DEMUX_ERR_RESP_EN
    if (sel == R_ERR) begin
      tgt_gnt = 1'b1;
    end
`endif
  end

  // read limit for the selected target. The error responder keeps one read in flight.
  always_comb begin
    lim = MAX_CNT;
`ifdef OBI_DEMUX_ERR_RESP_EN
    if (sel == R_ERR) begin
      lim = CW'(1);
    end
`endif
  end

  // response from the target that owns the outstanding reads
  always_comb begin
    route_rvalid = s0_rvalid_i;
    route_rdata  = s0_rdata_i;
    if (route == R_S1) begin
      route_rvalid = s1_rvalid_i;
      route_rdata  = s1_rdata_i;
    end
`ifdef OBI_DEMUX_ERR_RESP_EN
    if (route == R_ERR) begin
      route_rvalid = err_pending;
      route_rdata  = ERR_RDATA;
    end
`endif
  end

  // A response counts only while reads are outstanding. Responses at any
  // other time are spurious, for example after a reset mid-operation.
  assign rvalid_in = (cnt != '0) && route_rvalid;

  // Blocking rules: a request to a different target waits until every read
  // has drained, so responses cannot overtake each other. A full read
  // pipeline may take a new read in the same cycle one retires.
  assign same_route = (route == sel);
  assign allowed_rd = (cnt == '0)
                   || (same_route && (cnt < lim))
                   || (same_route && (cnt == lim) && rvalid_in);
  assign allowed_wr = (cnt == '0) || same_route;
  assign allowed    = m_we_i ? allowed_wr : allowed_rd;

  assign m_gnt_o   = allowed && tgt_gnt && m_req_i;
  assign rd_accept = m_req_i && m_gnt_o && !m_we_i;

  assign s0_req_o = m_req_i && (sel == R_S0) && allowed;
  assign s1_req_o = m_req_i && (sel == R_S1) && allowed;

  // address-phase payload goes to both slaves; only req is steered
  assign s0_addr_o  = m_addr_i;
  assign s0_we_o    = m_we_i;
  assign s0_be_o    = m_be_i;
  assign s0_wdata_o = m_wdata_i;
  assign s1_addr_o  = m_addr_i;
  assign s1_we_o    = m_we_i;
  assign s1_be_o    = m_be_i;
  assign s1_wdata_o = m_wdata_i;

  assign m_rvalid_o = rvalid_in;
  assign m_rdata_o  = rvalid_in ? route_rdata : 32'h0;

  // Track outstanding reads. An accept and a response in the same cycle
  // cancel out, and the blocking rules keep the counter from wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt   <= '0;
      route <= R_S0;
    end else begin
      if (rd_accept) begin
        route <= sel;
      end
      case ({rd_accept, rvalid_in})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef OBI_DEMUX_ERR_RESP_EN
  // The error responder answers each accepted unmapped read exactly one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_pending <= 1'b0;
    end else begin
      err_pending <= rd_accept && (sel == R_ERR);
    end
  end

  assign dbg_route_o = route;
`else
  assign dbg_route_o = {1'b0, route};
`endif

  assign dbg_cnt_o = cnt;

endmodule

// File: tb/tb_obi_demux_1_to_2.sv
// tb_obi_demux_1_to_2
// Directed bench for the 1-to-2 OBI demux. The stimulus process drives the
// master and both slave sides and checks the address-phase outputs. Each read
// it issues pushes its hand-computed read data onto exp_q. A separate monitor
// pops exp_q and compares whenever m_rvalid_o is high.
module tb_obi_demux_1_to_2;

  logic        clk;
  logic        rst;
  logic        m_req;
  logic        m_gnt;
  logic [31:0] m_addr;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        s0_req, s0_gnt, s0_we, s0_rvalid;
  logic [31:0] s0_addr, s0_wdata, s0_rdata;
  logic [3:0]  s0_be;
  logic        s1_req, s1_gnt, s1_we, s1_rvalid;
  logic [31:0] s1_addr, s1_wdata, s1_rdata;
  logic [3:0]  s1_be;
  logic [1:0]  dbg_cnt;
  logic [1:0]  dbg_route;

  int          tests_run = 0;
  int          fails     = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  obi_demux_1_to_2 dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m_req_i     (m_req),
    .m_gnt_o     (m_gnt),
    .m_addr_i    (m_addr),
    .m_we_i      (m_we),
    .m_be_i      (m_be),
    .m_wdata_i   (m_wdata),
    .m_rvalid_o  (m_rvalid),
    .m_rdata_o   (m_rdata),
    .s0_req_o    (s0_req),
    .s0_gnt_i    (s0_gnt),
    .s0_addr_o   (s0_addr),
    .s0_we_o     (s0_we),
    .s0_be_o     (s0_be),
    .s0_wdata_o  (s0_wdata),
    .s0_rvalid_i (s0_rvalid),
    .s0_rdata_i  (s0_rdata),
    .s1_req_o    (s1_req),
    .s1_gnt_i    (s1_gnt),
    .s1_addr_o   (s1_addr),
    .s1_we_o     (s1_we),
    .s1_be_o     (s1_be),
    .s1_wdata_o  (s1_wdata),
    .s1_rvalid_i (s1_rvalid),
    .s1_rdata_i  (s1_rdata),
    .dbg_cnt_o   (dbg_cnt),
    .dbg_route_o (dbg_route)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, required end within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  // checker shared by stimulus and monitor
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after posedge, checks at negedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    m_req   = 1'b1;
    m_addr  = addr;
    m_we    = we;
    m_be    = 4'hF;
    m_wdata = wdata;
  endtask

  task automatic drive_idle();
    m_req   = 1'b0;
    m_addr  = 32'h0;
    m_we    = 1'b0;
    m_be    = 4'h0;
    m_wdata = 32'h0;
  endtask

  task automatic drive_s0(input logic gnt, input logic rvalid, input logic [31:0] rdata);
    s0_gnt    = gnt;
    s0_rvalid = rvalid;
    s0_rdata  = rdata;
  endtask

  task automatic drive_s1(input logic gnt, input logic rvalid, input logic [31:0] rdata);
    s1_gnt    = gnt;
    s1_rvalid = rvalid;
    s1_rdata  = rdata;
  endtask

  task automatic check_cnt(input string name, input logic [1:0] exp);
    check(name, {30'h0, dbg_cnt}, {30'h0, exp});
  endtask

  // scoreboard monitor: every response must match the oldest expected read
  always @(negedge clk) begin
    if (m_rvalid) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL rsp_spurious: got rvalid with rdata %h, required no response", m_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rsp_rdata", m_rdata, mon_exp);
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive_idle();
    drive_s0(1'b0, 1'b0, 32'h0);
    drive_s1(1'b0, 1'b0, 32'h0);

    // reset state
    tick();
    tick();
    sample();
    check("rst_rvalid", {31'h0, m_rvalid}, 32'h0);
    check("rst_rdata", m_rdata, 32'h0);
    check("rst_gnt", {31'h0, m_gnt}, 32'h0);
    check("rst_reqs", {30'h0, s1_req, s0_req}, 32'h0);
    check_cnt("rst_cnt", 2'd0);
    tick();
    rst = 1'b0;

    // single read to slave 0, answered two cycles after the grant
    drive_req(32'h0000_0010, 1'b0, 32'h0);
    drive_s0(1'b1, 1'b0, 32'h0);
    exp_q.push_back(32'hA5A5_0001);
    sample();
    check("rd0_reqs", {30'h0, s1_req, s0_req}, 32'h1);
    check("rd0_gnt", {31'h0, m_gnt}, 32'h1);
    check("rd0_addr_bcast", s1_addr, 32'h0000_0010);
    tick();
    drive_idle();
    drive_s0(1'b0, 1'b0, 32'h0);
    sample();
    check_cnt("rd0_cnt1", 2'd1);
    check("rd0_s1_quiet", {31'h0, s1_req}, 32'h0);
    tick();
    drive_s0(1'b0, 1'b1, 32'hA5A5_0001);
    sample();
    check("rd0_rvalid", {31'h0, m_rvalid}, 32'h1);
    tick();
    drive_s0(1'b0, 1'b0, 32'h0);
    sample();
    check_cnt("rd0_cnt0", 2'd0);
    check("rd0_rvalid_drop", {31'h0, m_rvalid}, 32'h0);
    tick();

    // two pipelined reads to slave 1, the third stalls until the first response
    drive_s1(1'b1, 1'b0, 32'h0);
    drive_req(32'h1000_0000, 1'b0, 32'h0);
    exp_q.push_back(32'h1111_0000);
    sample();
    check("pipe_gnt1", {31'h0, m_gnt}, 32'h1);
    check("pipe_reqs1", {30'h0, s1_req, s0_req}, 32'h2);
    tick();
    drive_req(32'h1000_0004, 1'b0, 32'h0);
    exp_q.push_back(32'h1111_0004);
    sample();
    check("pipe_gnt2", {31'h0, m_gnt}, 32'h1);
    tick();
    drive_req(32'h1000_0008, 1'b0, 32'h0);
    exp_q.push_back(32'h1111_0008);
    sample();
    check_cnt("pipe_cnt2", 2'd2);
    check("pipe_stall_gnt", {31'h0, m_gnt}, 32'h0);
    check("pipe_stall_req", {31'h0, s1_req}, 32'h0);
    tick();
    sample();
    check("pipe_stall_gnt2", {31'h0, m_gnt}, 32'h0);
    tick();
    drive_s1(1'b1, 1'b1, 32'h1111_0000);
    sample();
    check("pipe_gnt3", {31'h0, m_gnt}, 32'h1);
    check("pipe_req3", {31'h0, s1_req}, 32'h1);
    tick();
    drive_idle();
    drive_s1(1'b0, 1'b1, 32'h1111_0004);
    sample();
    check_cnt("pipe_cnt_hold", 2'd2);
    tick();
    drive_s1(1'b0, 1'b1, 32'h1111_0008);
    sample();
    check_cnt("pipe_cnt_dec", 2'd1);
    tick();
    drive_s1(1'b0, 1'b0, 32'h0);
    sample();
    check_cnt("pipe_cnt0", 2'd0);
    tick();

    // read to slave 0 blocked behind an outstanding slave 1 read
    drive_s1(1'b1, 1'b0, 32'h0);
    drive_req(32'h1000_0010, 1'b0, 32'h0);
    exp_q.push_back(32'h2222_0010);
    sample();
    check("xr_gnt_s1", {31'h0, m_gnt}, 32'h1);
    tick();
    drive_s1(1'b0, 1'b0, 32'h0);
    drive_s0(1'b1, 1'b0, 32'h0);
    drive_req(32'h0000_0000, 1'b0, 32'h0);
    exp_q.push_back(32'h3333_0000);
    sample();
    check("xr_blk_req", {31'h0, s0_req}, 32'h0);
    check("xr_blk_gnt", {31'h0, m_gnt}, 32'h0);
    tick();
    drive_s1(1'b0, 1'b1, 32'h2222_0010);
    sample();
    check("xr_blk_gnt_rv", {31'h0, m_gnt}, 32'h0);
    check("xr_blk_req_rv", {31'h0, s0_req}, 32'h0);
    tick();
    drive_s1(1'b0, 1'b0, 32'h0);
    sample();
    check("xr_free_req", {31'h0, s0_req}, 32'h1);
    check("xr_free_gnt", {31'h0, m_gnt}, 32'h1);
    tick();
    drive_idle();
    drive_s0(1'b0, 1'b0, 32'h0);
    sample();
    check("xr_route0", {30'h0, dbg_route}, 32'h0);
    tick();
    drive_s0(1'b0, 1'b1, 32'h3333_0000);
    tick();
    drive_s0(1'b0, 1'b0, 32'h0);
    sample();
    check_cnt("xr_cnt0", 2'd0);
    tick();

    // accept and response in the same cycle, plus spurious responses
    drive_s0(1'b1, 1'b0, 32'h0);
    drive_req(32'h0000_0020, 1'b0, 32'h0);
    exp_q.push_back(32'h4444_0020);
    tick();
    drive_req(32'h0000_0024, 1'b0, 32'h0);
    drive_s0(1'b1, 1'b1, 32'h4444_0020);
    exp_q.push_back(32'h4444_0024);
    sample();
    check("same_gnt", {31'h0, m_gnt}, 32'h1);
    check_cnt("same_cnt_pre", 2'd1);
    tick();
    drive_idle();
    drive_s0(1'b0, 1'b0, 32'h0);
    drive_s1(1'b0, 1'b1, 32'hDEAD_0001);
    sample();
    check_cnt("same_cnt_hold", 2'd1);
    check("spur_s1_rvalid", {31'h0, m_rvalid}, 32'h0);
    tick();
    drive_s1(1'b0, 1'b0, 32'h0);
    drive_s0(1'b0, 1'b1, 32'h4444_0024);
    sample();
    check_cnt("spur_s1_cnt", 2'd1);
    tick();
    drive_s0(1'b0, 1'b1, 32'hDEAD_0002);
    sample();
    check_cnt("spur_cnt0", 2'd0);
    check("spur_s0_rvalid", {31'h0, m_rvalid}, 32'h0);
    check("spur_s0_rdata", m_rdata, 32'h0);
    tick();
    drive_s0(1'b0, 1'b0, 32'h0);
    sample();
    check_cnt("spur_cnt_stay", 2'd0);
    tick();

    // write to slave 1 blocked behind a slave 0 read; writes never count
    drive_s0(1'b1, 1'b0, 32'h0);
    drive_req(32'h0000_0030, 1'b0, 32'h0);
    exp_q.push_back(32'h5555_0030);
    tick();
    drive_s0(1'b0, 1'b0, 32'h0);
    drive_s1(1'b1, 1'b0, 32'h0);
    drive_req(32'h1000_0040, 1'b1, 32'hCAFE_F00D);
    sample();
    check("wr_blk_gnt", {31'h0, m_gnt}, 32'h0);
    check("wr_blk_req", {31'h0, s1_req}, 32'h0);
    check("wr_wdata_bcast", s0_wdata, 32'hCAFE_F00D);
    check("wr_we_bcast", {31'h0, s1_we}, 32'h1);
    tick();
    drive_s0(1'b0, 1'b1, 32'h5555_0030);
    sample();
    check("wr_blk_gnt_rv", {31'h0, m_gnt}, 32'h0);
    tick();
    drive_s0(1'b0, 1'b0, 32'h0);
    sample();
    check("wr_gnt", {31'h0, m_gnt}, 32'h1);
    check("wr_req", {31'h0, s1_req}, 32'h1);
    tick();
    drive_idle();
    drive_s1(1'b0, 1'b0, 32'h0);
    sample();
    check_cnt("wr_cnt0", 2'd0);
    tick();

    // reset with two reads outstanding drops them
    drive_s1(1'b1, 1'b0, 32'h0);
    drive_req(32'h1000_0000, 1'b0, 32'h0);
    tick();
    drive_req(32'h1000_0004, 1'b0, 32'h0);
    tick();
    drive_idle();
    drive_s1(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    sample();
    check_cnt("mrst_cnt2", 2'd2);
    tick();
    rst = 1'b0;
    drive_s1(1'b0, 1'b1, 32'hDEAD_0003);
    sample();
    check_cnt("mrst_cnt0", 2'd0);
    check("mrst_rvalid", {31'h0, m_rvalid}, 32'h0);
    tick();
    drive_s1(1'b0, 1'b0, 32'h0);
    drive_s0(1'b1, 1'b0, 32'h0);
    drive_req(32'h0000_0000, 1'b0, 32'h0);
    exp_q.push_back(32'h6666_0000);
    sample();
    check("mrst_gnt", {31'h0, m_gnt}, 32'h1);
    check("mrst_req", {31'h0, s0_req}, 32'h1);
    tick();
    drive_idle();
    drive_s0(1'b0, 1'b1, 32'h6666_0000);
    tick();
    drive_s0(1'b0, 1'b0, 32'h0);
    tick();

`ifdef OBI_DEMUX_ERR_RESP_EN
    // unmapped read answered by the internal responder
    drive_req(32'h2000_0000, 1'b0, 32'h0);
    exp_q.push_back(32'hBADC_AB1E);
    sample();
    check("err_gnt", {31'h0, m_gnt}, 32'h1);
    check("err_reqs", {30'h0, s1_req, s0_req}, 32'h0);
    tick();
    drive_req(32'h3000_0000, 1'b1, 32'h1234_5678);
    sample();
    check("err_rvalid", {31'h0, m_rvalid}, 32'h1);
    check("err_wr_gnt", {31'h0, m_gnt}, 32'h1);
    check("err_wr_reqs", {30'h0, s1_req, s0_req}, 32'h0);
    tick();
    drive_idle();
    sample();
    check_cnt("err_cnt0", 2'd0);
    tick();
`else
    // without the error region, any non-slave-1 address belongs to slave 0
    drive_s0(1'b1, 1'b0, 32'h0);
    drive_req(32'h2000_0000, 1'b1, 32'h1234_5678);
    sample();
    check("s0_region_reqs", {30'h0, s1_req, s0_req}, 32'h1);
    check("s0_region_gnt", {31'h0, m_gnt}, 32'h1);
    tick();
    drive_idle();
    drive_s0(1'b0, 1'b0, 32'h0);
    sample();
    check_cnt("s0_region_cnt", 2'd0);
    tick();
`endif

    tick();
    check("queue_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
